// File: rtl/crc_pkg.sv
// Shared size encodings and elaboration helpers for the CRC byte sequencer slice.
package crc_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd3
    } size_code_e;

    // Width of a pointer into a DEPTH-entry store; a single-entry store still needs one bit.
    function automatic int clog2_safe(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/crc_sync_fifo.sv
// Synchronous FIFO holding {data, size, rst_tag} entries, with an extra port that can
// set the tag bit of any stored entry.
module crc_sync_fifo
    import crc_pkg::*;
#(
    parameter int  WIDTH = 35,
    parameter int  DEPTH = 2,
    localparam int PTR_W = clog2_safe(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_entry,
    input  logic             pop,
    input  logic             tag_set,
    input  logic [PTR_W-1:0] tag_idx,
    output logic [WIDTH-1:0] head_entry,
    output logic [PTR_W-1:0] tail_ptr,
    output logic [LVL_W-1:0] level,
    output logic             any_tag
);

    logic [WIDTH-2:0] mem_r [DEPTH];
    logic [DEPTH-1:0] tag_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [LVL_W-1:0] level_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    // Pointers, occupancy and tag bits; tags are dropped as their entry leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            level_r <= {LVL_W{1'b0}};
            tag_r   <= {DEPTH{1'b0}};
        end else begin
            if (push) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (pop) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (tail_r == PTR_W'(i))) begin
                    tag_r[i] <= push_entry[0];
                end else if (pop && (head_r == PTR_W'(i))) begin
                    tag_r[i] <= 1'b0;
                end else if (tag_set && (tag_idx == PTR_W'(i))) begin
                    tag_r[i] <= 1'b1;
                end
            end
        end
    end

    // Payload storage; contents of empty slots are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[tail_r] <= push_entry[WIDTH-1:1];
        end
    end

    assign head_entry = {mem_r[head_r], tag_r[head_r]};
    assign tail_ptr   = tail_r;
    assign level      = level_r;
    assign any_tag    = |tag_r;

endmodule

// File: rtl/crc_byte_sequencer.sv
// Queues sized words and serialises them one byte per cycle into the CRC datapath,
// driving the chained-CRC set/clear controls alongside.
module crc_byte_sequencer
    import crc_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 2,
    parameter int  SIZE_W = $clog2(DATA_W / 8),
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SIZE_W-1:0] wr_size,
    input  logic              reset_chain,
    output logic              buffer_full,
    output logic              read_wait,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic [SIZE_W-1:0] byte_sel,
    output logic              last_byte,
    output logic              set_crc_init_sel,
    output logic              clear_crc_init_sel,
    output logic              reset_pending,
    output logic [LVL_W-1:0]  level
);

    localparam int BYTES   = DATA_W / 8;
    localparam int ENTRY_W = DATA_W + SIZE_W + 1;
    localparam int PTR_W   = clog2_safe(DEPTH);

    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic [DATA_W-1:0]  head_data_s;
    logic [SIZE_W-1:0]  head_size_s;
    logic               head_tag_s;
    logic [SIZE_W-1:0]  size_in_s;
    logic [SIZE_W-1:0]  byte_sel_r;
    logic [PTR_W-1:0]   tail_ptr_s;
    logic [PTR_W-1:0]   tag_idx_s;
    logic [LVL_W-1:0]   level_s;
    logic               any_tag_s;
    logic               byte_valid_s;
    logic               last_byte_s;
    logic               pop_s;
    logic               full_s;
    logic               accept_s;
    logic               tag_set_s;
    logic               late_tag_s;
    logic               idle_clear_s;

    assign {head_data_s, head_size_s, head_tag_s} = head_entry_s;

    assign byte_valid_s = (level_s != {LVL_W{1'b0}});
    assign last_byte_s  = byte_valid_s && (byte_sel_r == head_size_s);
    assign pop_s        = last_byte_s;
    assign full_s       = (level_s == LVL_W'(DEPTH)) && !pop_s;
    assign accept_s     = write && !full_s;
    assign tag_set_s    = reset_chain && !accept_s && byte_valid_s;
    // A tag aimed at a lone entry that leaves this very cycle would be lost, so honour it now.
    assign late_tag_s   = tag_set_s && pop_s && (level_s == LVL_W'(1));
    assign idle_clear_s = reset_chain && !byte_valid_s && !accept_s;
    assign push_entry_s = {wr_data, size_in_s, reset_chain};

    // Size capture; only reachable when BYTES is not a power of two.
    always_comb begin
        if (wr_size > SIZE_W'(BYTES - 1)) begin
            size_in_s = SIZE_W'(BYTES - 1);
        end else begin
            size_in_s = wr_size;
        end
    end

    // Most recently accepted entry sits one slot behind the tail pointer.
    always_comb begin
        if (tail_ptr_s == {PTR_W{1'b0}}) begin
            tag_idx_s = PTR_W'(DEPTH - 1);
        end else begin
            tag_idx_s = tail_ptr_s - PTR_W'(1);
        end
    end

    crc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .tag_set    (tag_set_s),
        .tag_idx    (tag_idx_s),
        .head_entry (head_entry_s),
        .tail_ptr   (tail_ptr_s),
        .level      (level_s),
        .any_tag    (any_tag_s)
    );

    // Byte index within the head word; restarts at 0 for the next word without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_sel_r <= {SIZE_W{1'b0}};
        end else if (pop_s || !byte_valid_s) begin
            byte_sel_r <= {SIZE_W{1'b0}};
        end else begin
            byte_sel_r <= byte_sel_r + SIZE_W'(1);
        end
    end

    // Output decode from FIFO state and byte counter.
    always_comb begin
        byte_valid         = byte_valid_s;
        read_wait          = byte_valid_s;
        last_byte          = last_byte_s;
        byte_sel           = byte_sel_r;
        buffer_full        = full_s;
        level              = level_s;
        reset_pending      = any_tag_s;
        set_crc_init_sel   = byte_valid_s && (byte_sel_r == {SIZE_W{1'b0}});
        clear_crc_init_sel = (pop_s && (head_tag_s || late_tag_s)) || idle_clear_s;
        if (byte_valid_s) begin
            byte_out = head_data_s[{byte_sel_r, 3'b000} +: 8];
        end else begin
            byte_out = 8'h00;
        end
    end

endmodule
